// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for an eight-digit, common-anode seven-segment
// display. A prescaler sets how long each digit stays lit. A digit index
// walks across the eight digits. A shadow copy of the display word is
// reloaded only at the end of a full scan, so a frame never shows a mix of
// old and new data. Leading-zero blanking is optional. All outputs are
// registered and active-low.

module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] display_data,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    // The prescaler is exactly ceil(log2(REFRESH_DIV)) bits wide.
    localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Hex nibble to {g,f,e,d,c,b,a} cathode pattern (active low)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // True when every nibble from the selected digit upward is zero
    function automatic logic upper_zero(input logic [31:0] word, input logic [2:0] digit);
        logic [31:0] upper;
        upper = word >> {digit, 2'b00};
        return (upper == 32'd0);
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [31:0]      shadow_r;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             frame_tick_r;

    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       idx_next_s;
    logic             last_s;
    logic             frame_end_s;
    logic [3:0]       nibble_s;
    logic             blank_s;
    logic [7:0]       an_next_s;
    logic [6:0]       seg_next_s;

    // Prescaler wrap, digit advance and frame boundary detection
    always_comb begin
        cnt_next_s  = cnt_r;
        idx_next_s  = idx_r;
        last_s      = (cnt_r == CNT_MAX);
        frame_end_s = last_s && (idx_r == 3'd7);
        if (last_s) begin
            cnt_next_s = {CNT_W{1'b0}};
            idx_next_s = idx_r + 3'd1;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
            idx_next_s = idx_r;
        end
    end

    // Next anode/cathode pattern from the current digit and shadow word
    always_comb begin
        nibble_s   = shadow_r[{idx_r, 2'b00} +: 4];
        blank_s    = 1'b0;
        an_next_s  = 8'hFF;
        seg_next_s = 7'h7F;
        if (BLANK_LZ && (idx_r != 3'd0) && upper_zero(shadow_r, idx_r)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
        if (blank_s) begin
            an_next_s  = 8'hFF;
            seg_next_s = 7'h7F;
        end else begin
            an_next_s  = ~(8'd1 << idx_r);
            seg_next_s = hex_to_seg(nibble_s);
        end
    end

    // Scan state, shadow reload and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= 3'd0;
            shadow_r     <= 32'd0;
            an_r         <= 8'hFF;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_next_s;
            idx_r        <= idx_next_s;
            an_r         <= an_next_s;
            seg_r        <= seg_next_s;
            dp_r         <= 1'b1;
            frame_tick_r <= frame_end_s;
            if (frame_end_s) begin
                shadow_r <= display_data;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, gives the clk cycles each digit stays lit; legal values are 2 or more.
REQ-002 Parameter BLANK_LZ, default 1, enables leading-zero blanking when set to 1.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port display_data, input, 32 bits: the processor's display word (eight hex nibbles), driven by the core's display_data output.
REQ-006 Port an, output, 8 bits: active-low digit anodes; an[i] selects digit i, and digit 0 is the least-significant nibble.
REQ-007 Port seg, output, 7 bits: active-low cathodes, bit order {g,f,e,d,c,b,a}, so seg[0]=a.
REQ-008 Port dp, output, 1 bit: active-low decimal point.
REQ-009 Port frame_tick, output, 1 bit: one-cycle pulse marking a shadow-register reload.

Function
REQ-010 Prescaler cnt SHALL count 0..REFRESH_DIV-1, wrap to 0, and be as wide as ceil(log2(REFRESH_DIV)).
REQ-011 3-bit digit index idx SHALL advance by 1 (7 wraps to 0) on every edge where cnt==REFRESH_DIV-1; it is held at all other edges.
REQ-012 32-bit shadow register SHALL load display_data only on the edge where cnt==REFRESH_DIV-1 and idx==7, so a frame never tears.
REQ-013 frame_tick SHALL be registered, high for exactly one cycle following each shadow load, and low otherwise.
REQ-014 an, seg and dp SHALL be registered and reflect the idx and shadow values present before the edge: one cycle of latency.
REQ-015 Digit i SHALL display nibble shadow[4i+3:4i]; an SHALL equal ~(1<<idx) unless the digit is blanked.
REQ-016 Hex decode, giving seg as {g..a}:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-017 With BLANK_LZ=1, digit i>0 SHALL be blanked when shadow[31:4i]==0; a blanked digit drives an=8'hFF and seg=7'h7F. Digit 0 is never blanked.
REQ-018 With BLANK_LZ=0, no digit SHALL ever be blanked.
REQ-019 dp SHALL be held at 1 (off) permanently.
REQ-020 At most one an bit SHALL be low in any cycle.
REQ-021 A display_data change mid-frame SHALL NOT affect any output until the next shadow load.

Reset
REQ-022 Asserting reset SHALL immediately force cnt=0, idx=0, shadow=0, an=8'hFF, seg=7'h7F, dp=1 and frame_tick=0, independent of clk.
REQ-023 On the first edge after reset deasserts, outputs SHALL become an=8'hFE, seg=7'b1000000 (digit 0 shows "0").
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no shadow load or frame_tick pulse SHALL occur while reset is high.

Verification (REFRESH_DIV=4)
REQ-025 Reset, then display_data=32'h12345678 held -> first frame shows "0" on digit 0 with digits 1-7 blanked; frame_tick pulses one cycle after edge 32; the second frame shows an=FE/seg=0000000 ("8"), then FD/"7" ... up to 7F/"1", each held 4 cycles.
REQ-026 BLANK_LZ=1, display_data=32'h000000A5 -> per frame only digits 0 ("5", 0010010) and 1 ("A", 0001000) light; slots 2-7 show an=FF, seg=7F.
REQ-027 BLANK_LZ=0, display_data=32'h00000000 -> all eight digits light in turn with seg=1000000.
REQ-028 display_data changed from 32'h1 to 32'hF while idx==3 -> digit 0 keeps showing "1" until after the next shadow load, then shows "F" (0001110).
REQ-029 Reset pulsed while idx==5 -> outputs go to FF/7F/dp=1 without waiting for clk; scanning restarts at digit 0 and frame_tick stays low until the next complete frame.
REQ-030 Across all scenarios, an SHALL never have more than one low bit.
